// File: rtl/mul17_share_sched_pkg.sv
// Shared widths and FSM encodings for the shared multiply-by-17 scheduler.
package mul17_share_sched_pkg;
   localparam int W_DEF     = 8;
   localparam int CNT_W_DEF = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_CALC = ST_CALC,
      S_HOLD = ST_HOLD
   } state_t;
endpackage

// File: rtl/mul17_share_sched_if.sv
// Requester handshakes plus the tagged result bus toward the consumer.
interface mul17_share_sched_if #(parameter int W = 8);
   logic           req0;
   logic [W-1:0]   a0;
   logic           ack0;
   logic           req1;
   logic [W-1:0]   a1;
   logic           ack1;
   logic [2*W-1:0] res;
   logic           res_id;
   logic           res_valid;
   logic           res_ready;

   modport master (
      output req0, a0, req1, a1, res_ready,
      input  ack0, ack1, res, res_id, res_valid
   );

   modport slave (
      input  req0, a0, req1, a1, res_ready,
      output ack0, ack1, res, res_id, res_valid
   );
endinterface

// File: rtl/mul17_share_sched_core.sv
// Combinational a*17 as (a<<4)+a, zero-extended to 2W so nothing truncates.
module mul17_core #(
   parameter int W = 8
) (
   input  logic [W-1:0]   a,
   output logic [2*W-1:0] p
);
   logic [2*W-1:0] ax;

   assign ax = {{W{1'b0}}, a};
   assign p  = (ax << 4) + ax;
endmodule

// File: rtl/mul17_share_sched.sv
// Round-robin two-requester scheduler sharing one mul17 datapath,
// holding each tagged result until accepted and counting completions.
module mul17_share_sched
   import mul17_share_sched_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             Reset,
   mul17_share_sched_if.slave bus,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt,
   output logic             OV
);
   state_t         state, state_nxt;
   logic [W-1:0]   op_reg;
   logic           id_reg;
   logic           last_id;
   logic           gnt;
   logic           gnt_vld;
   logic [2*W-1:0] prod;

   mul17_core #(.W(W)) u_core (.a(op_reg), .p(prod));

   assign busy = (state != S_IDLE);

   // Ties go to whoever did not win last; a lone request wins outright.
   always_comb begin
      gnt_vld   = bus.req0 | bus.req1;
      gnt       = (bus.req0 && bus.req1) ? ~last_id : bus.req1;
      state_nxt = state;
      case (state)
         S_IDLE:  if (gnt_vld) state_nxt = S_CALC;
         S_CALC:  state_nxt = S_HOLD;
         S_HOLD:  if (bus.res_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         bus.ack0      <= 1'b0;
         bus.ack1      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res       <= '0;
         bus.res_id    <= 1'b0;
         done_cnt      <= '0;
         OV            <= 1'b0;
         last_id       <= 1'b1;
         op_reg        <= '0;
         id_reg        <= 1'b0;
      end else begin
         bus.ack0 <= 1'b0;
         bus.ack1 <= 1'b0;
         OV       <= 1'b0;
         case (state)
            S_IDLE: if (gnt_vld) begin
               op_reg   <= gnt ? bus.a1 : bus.a0;
               id_reg   <= gnt;
               last_id  <= gnt;
               bus.ack0 <= ~gnt;
               bus.ack1 <= gnt;
            end
            S_CALC: begin
               bus.res       <= prod;
               bus.res_id    <= id_reg;
               bus.res_valid <= 1'b1;
            end
            S_HOLD: if (bus.res_ready) begin
               bus.res_valid <= 1'b0;
               done_cnt      <= done_cnt + CNT_W'(1);
               OV            <= &done_cnt;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/mul17_share_sched.md
Name: mul17_share_sched

Overview:
- Two-requester scheduler that time-shares one multiply-by-17 datapath, computed as (a<<4)+a.
- Each requester presents an operand with a request. The block arbitrates round-robin, captures the winner's operand, computes, and holds the tagged result until the consumer accepts it.
- Keeps a wrapping completed-operation counter with an overflow flag, matching the team's 8-bit counter idiom.
- Sits between the operand counters/sources and the downstream result consumer.

Parameters:
- W, 8, operand width; must be >= 5 so that a*17 fits in 2W bits.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled only at the rising edge of clk.
- req0  in  1  requester 0 request; hold high with a0 stable until ack0 is seen.
- a0  in  W  requester 0 operand.
- ack0  out  1  one-cycle pulse: a0 has been captured.
- req1  in  1  requester 1 request.
- a1  in  W  requester 1 operand.
- ack1  out  1  one-cycle pulse: a1 has been captured.
- res  out  2W  registered product, operand*17, zero-extended.
- res_id  out  1  requester that owns res (0 or 1).
- res_valid  out  1  res and res_id are valid.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever the FSM is not in IDLE.
- done_cnt  out  CNT_W  count of accepted results; wraps from all-ones to 0.
- OV  out  1  one-cycle pulse on the edge where done_cnt wraps to 0.

Behaviour:
- Reset (Reset=0 at an edge):
  - State goes to IDLE.
  - ack0, ack1, res_valid, res, res_id, done_cnt and OV all go to 0.
  - last_id goes to 1, so requester 0 wins the first tie.
  - Reset in any state discards the in-flight operation: no ack, no result, no count.
- FSM states: IDLE, CALC, HOLD. The unused encoding goes to IDLE. busy = (state != IDLE).
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one of req0/req1 high: grant it.
  - Both high: grant ~last_id.
  - On a grant: op_reg <= a[grant], id_reg <= grant, last_id <= grant, ack[grant] <= 1 for one cycle, state <= CALC.
  - No request: remain in IDLE.
- CALC (one cycle):
  - res <= mul17(op_reg), res_id <= id_reg, res_valid <= 1, acks <= 0, state <= HOLD.
- HOLD:
  - res, res_id and res_valid are held stable.
  - At an edge with res_ready=1: res_valid <= 0, done_cnt <= done_cnt+1, state <= IDLE.
  - OV <= 1 if done_cnt was all-ones, else OV <= 0.
  - res_ready is ignored outside HOLD.
- Timing:
  - Grant at edge k: ack visible from k to k+1; res_valid visible from k+1.
  - Earliest acceptance at edge k+2; next request sampled at edge k+3.
  - Peak throughput is one operation per 3 cycles.
- Requester obligation:
  - Drop req within 2 cycles after ack, i.e. before edge k+3 at the earliest.
  - A req still high at the next IDLE sample is treated as a new request.
  - The ungranted requester keeps waiting. With both requesters continuously active, grants alternate strictly.
- Arithmetic: res = {op,4'b0} + op, zero-extended to 2W. Max 255*17 = 4335 (16'h10EF) for W=8, so no truncation.
- OV is low on every cycle except the wrap edge's following cycle.

Decomposition:
- Shared package holds:
  - state localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_HOLD=2'd2;
  - default widths W=8, CNT_W=8.
- One combinational sub-module, mul17_core (input a[W], output p[2W], p = (a<<4)+a), instantiated once.
- Arbitration, FSM and counter stay in the top module.

Test Plan:
1. Hold Reset low 3 cycles with req0=1, a0=8'h0A → all outputs stay 0, no ack. Release → ack0 pulses at the next edge.
2. Single req0, a0=8'h0A, res_ready=1 → ack0 one cycle, then res_valid with res=16'h00AA, res_id=0. Accepted next edge; done_cnt=1, busy drops.
3. req0 and req1 together, a0=8'hFF, a1=8'h03, both held → first res=16'h10EF id 0, then res=16'h0033 id 1. Grants continue alternating 0,1,0,1.
4. res_ready low 5 cycles in HOLD with req1 pending → res, res_id and res_valid stable; busy=1; ack1 not issued until acceptance and return to IDLE.
5. 256 back-to-back accepted operations → done_cnt goes 255→0, OV high for exactly one cycle, then low.
6. Reset asserted during HOLD (res_valid=1) → next edge res_valid=0, done_cnt=0, state IDLE. The discarded operation is not counted or re-issued.
